// File: rtl/sine_pkg.sv
// Shared definitions for the time-multiplexed sine voice scheduler:
// sample/phase widths, saturation limits and the FSM state encoding.
package sine_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PHASE_W  = 32;

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sine_phase_bank.sv
// Per-voice phase accumulators, increments and gates.
// Ports: clk, reset (sync, active-high); cfg_we/cfg_voice/cfg_inc/cfg_gate
// config write; issue_en/issue_voice select the voice being issued,
// issue_addr/issue_gate return its pre-increment LUT address and gate.
module sine_phase_bank
    import sine_pkg::*;
#(
    parameter int NV     = 4,
    parameter int VW     = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [VW-1:0]     cfg_voice,
    input  logic [31:0]       cfg_inc,
    input  logic              cfg_gate,
    input  logic              issue_en,
    input  logic [VW-1:0]     issue_voice,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              issue_gate
);

    logic [PHASE_W-1:0] phase [NV];
    logic [PHASE_W-1:0] inc   [NV];
    logic [NV-1:0]      gate;
    logic [NV-1:0]      wr;
    logic [NV-1:0]      iss;

    // Indices >= NV never match any voice, so such writes fall away.
    always_comb begin
        wr  = '0;
        iss = '0;
        for (int i = 0; i < NV; i++) begin
            wr[i]  = cfg_we && (cfg_voice == VW'(i));
            iss[i] = issue_en && (issue_voice == VW'(i));
        end
    end

    assign issue_addr = phase[issue_voice][PHASE_W-1 -: ADDR_W];
    assign issue_gate = gate[issue_voice];

    // Issue reads the old inc/gate; a gate-off write clears the phase
    // and takes priority over a coincident advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
            end
            gate <= '0;
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (wr[i]) begin
                    inc[i]  <= cfg_inc;
                    gate[i] <= cfg_gate;
                end
                if (wr[i] && !cfg_gate) begin
                    phase[i] <= '0;
                end else if (iss[i]) begin
                    phase[i] <= gate[i] ? phase[i] + inc[i] : '0;
                end
            end
        end
    end

endmodule

// File: rtl/sine_voice_sched.sv
// Shares one sine LUT among NV voices: one lookup per voice per tick,
// returns summed and saturated into a single 16-bit mix.
// Ports: clk, reset (sync, active-high), sample_tick, cfg_* voice config,
// lut_req/lut_addr/lut_data LUT port, mix_out/mix_valid, busy, overrun.
module sine_voice_sched
    import sine_pkg::*;
#(
    parameter int NV      = 4,
    parameter int ADDR_W  = 10,
    parameter int LUT_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_tick,
    input  logic                      cfg_we,
    input  logic [$clog2(NV)-1:0]     cfg_voice,
    input  logic [31:0]               cfg_inc,
    input  logic                      cfg_gate,
    output logic                      lut_req,
    output logic [ADDR_W-1:0]         lut_addr,
    input  logic [SAMPLE_W-1:0]       lut_data,
    output logic [SAMPLE_W-1:0]       mix_out,
    output logic                      mix_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int VW    = $clog2(NV);
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int TOP   = LUT_LAT - 1;

    // Pattern seen in DRAIN when only the final return is still in flight.
    localparam logic [LUT_LAT-1:0] LAST_ONLY =
        LUT_LAT'(1 << (LUT_LAT - 1));

    state_t state;
    state_t nxt;

    logic [VW-1:0]            v;
    logic [LUT_LAT-1:0]       pv;
    logic [LUT_LAT-1:0]       pg;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  ret;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic [ADDR_W-1:0]        bank_addr;
    logic                     bank_gate;

    sine_phase_bank #(
        .NV     (NV),
        .VW     (VW),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_inc     (cfg_inc),
        .cfg_gate    (cfg_gate),
        .issue_en    (lut_req),
        .issue_voice (v),
        .issue_addr  (bank_addr),
        .issue_gate  (bank_gate)
    );

    function automatic logic [SAMPLE_W-1:0] sat(
        input logic signed [ACC_W-1:0] a
    );
        if (a > ACC_W'(SAT_MAX)) begin
            return SAMPLE_W'(SAT_MAX);
        end else if (a < ACC_W'(SAT_MIN)) begin
            return SAMPLE_W'(SAT_MIN);
        end
        return a[SAMPLE_W-1:0];
    endfunction

    // Gated-off voices still occupy a slot; their sample is masked.
    always_comb begin
        ret = '0;
        if (pv[TOP] && pg[TOP]) begin
            ret = ACC_W'($signed(lut_data));
        end
        acc_nxt = acc + ret;
    end

    always_comb begin
        nxt       = state;
        lut_req   = 1'b0;
        lut_addr  = '0;
        busy      = 1'b0;
        mix_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_tick) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                lut_req  = 1'b1;
                lut_addr = bank_addr;
                busy     = 1'b1;
                if (v == VW'(NV - 1)) begin
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pv == LAST_ONLY) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                mix_valid = 1'b1;
                nxt       = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            v       <= '0;
            pv      <= '0;
            pg      <= '0;
            acc     <= '0;
            mix_out <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= nxt;
            overrun <= sample_tick && (state != IDLE);
            pv      <= (pv << 1) | LUT_LAT'(lut_req);
            pg      <= (pg << 1) | LUT_LAT'(lut_req && bank_gate);
            if (state == IDLE && sample_tick) begin
                v   <= '0;
                acc <= '0;
            end else begin
                if (state == ISSUE) begin
                    v <= v + 1'b1;
                end
                if (pv[TOP]) begin
                    acc <= acc_nxt;
                end
            end
            // Register the mix from the final sum so mix_out is
            // already updated in the cycle mix_valid is high.
            if (state == DRAIN && nxt == DONE) begin
                mix_out <= sat(acc_nxt);
            end
        end
    end

endmodule

// File: doc/sine_voice_sched.md
Name: sine_voice_sched

Overview:
- Time-multiplexes one shared sine lookup table (LUT) among NV oscillator voices.
- Each voice has its own 32-bit phase accumulator, increment and gate.
- On every sample_tick the block issues one LUT lookup per voice, accumulates the returned samples, and emits one saturated 16-bit mixed sample.
- Sits between the sample-rate tick generator and the shared sine LUT. Replaces one free-running sinewave instance per voice. System clock is 10 MHz.

Parameters:
- NV, 4, number of voices (2..16).
- ADDR_W, 10, LUT address width; address = phase[31:32-ADDR_W].
- LUT_LAT, 2, fixed LUT read latency in cycles (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe at the sample rate.
- cfg_we  in  1  configuration write strobe.
- cfg_voice  in  clog2(NV)  voice index for the write.
- cfg_inc  in  32  phase increment for that voice.
- cfg_gate  in  1  voice enable.
- lut_req  out  1  lookup issue strobe.
- lut_addr  out  ADDR_W  lookup address.
- lut_data  in  16  signed sample; valid exactly LUT_LAT cycles after lut_req.
- mix_out  out  16  signed saturated mix, held until the next mix.
- mix_valid  out  1  one-cycle strobe when mix_out updates.
- busy  out  1  high from the cycle after the accepted tick until mix_valid, inclusive.
- overrun  out  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset: FSM=IDLE; all phases, incs, gates=0; accumulator=0; mix_out=0; mix_valid, lut_req, busy, overrun=0; lut_addr=0.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: sample_tick=1 -> ISSUE, voice index v=0, accumulator cleared.
- ISSUE: one voice per cycle, v=0..NV-1.
  - lut_req=1 and lut_addr=phase[v][31:32-ADDR_W], using the pre-increment phase.
  - Same edge: phase[v] <= phase[v]+inc[v] mod 2^32 (natural wrap).
  - After v=NV-1 -> DRAIN.
- Gate handling: if gate[v]=0, phase[v] is forced to 0 and the lookup is still issued. Its returned sample is masked to 0, so timing is constant.
- Return pipeline: a LUT_LAT-deep shift register carries valid+gate flags. Each returned lut_data, sign-extended to 16+clog2(NV) bits, is added to the accumulator on the cycle it arrives.
- DRAIN: waits until the last return has been accumulated -> DONE.
- DONE: mix_out <= accumulator saturated to [-32768, 32767]; mix_valid=1 for one cycle -> IDLE.
- Latency: tick at cycle T -> lut_req in cycles T+1..T+NV -> mix_valid at cycle T+NV+LUT_LAT+1. Example: NV=4, LUT_LAT=2 gives mix_valid at T+7.
- sample_tick while not IDLE, including the DONE cycle: the tick is dropped, overrun=1 next cycle, and the current computation is unaffected.
- Config writes are accepted in any state on the cycle cfg_we=1.
  - Values take effect from that voice's next issue.
  - A write to the voice being issued in the same cycle: the issue uses the old inc/gate; the new value is stored.
  - A cfg_gate 1->0 write also clears that voice's phase.
  - The phase is not reset on a gate 0->1 write (it is already 0).
- Reset asserted mid-run: everything returns to reset values on the next edge. No mix_valid is emitted, and in-flight LUT returns are ignored because the valid pipeline is cleared.
- Out-of-range cfg_voice (>= NV): the write is ignored.

Decomposition:
- Shared package sine_pkg holds:
  - SAMPLE_W=16, PHASE_W=32.
  - The FSM state encoding (IDLE, ISSUE, DRAIN, DONE).
  - The saturation limits.
- Sub-module sine_phase_bank holds NV phase/inc/gate registers. It provides:
  - a config write port;
  - an issue-time read/advance port that returns the current phase and gate and performs the increment or clear.
- The top level keeps the FSM, the return pipeline, the accumulator and saturation.

Test Plan (LUT model returns lut_data = addr as a signed value, delayed LUT_LAT):
1. Voice0 inc=0x0040_0000, gate=1, others gate=0; three ticks -> lut_addr for v0 = 0, 1, 2 (ADDR_W=10); mix_out = 0, 1, 2; mix_valid 7 cycles after each tick.
2. Voice0 phase 0xFFC0_0000, inc=0x0080_0000 -> addr 1023, then wraps to addr 1 on the next tick; no glitch in the accumulator.
3. All 4 voices gated on, LUT model forced to 0x7000 -> sum 0x1C000 saturates, mix_out=0x7FFF; forced to 0x9000 -> mix_out=0x8000.
4. Second sample_tick 3 cycles after the first -> overrun pulse 1 cycle later; exactly one mix_valid; busy high for 7 cycles.
5. reset asserted at cycle T+3 of a run -> no mix_valid; mix_out=0; next tick after reset yields a correct fresh mix from phase 0.
6. cfg write gate=0 to voice2 while voice2 is issuing -> that mix still includes voice2; the next mix excludes it and voice2's phase reads 0.
